ber_meter: RTL and testbench

BER_METER -- requirements
Module: ber_meter

---
 rtl/ber_meter.sv | 136 +++++++++++++
 tb/tb_ber_meter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ber_meter.sv
// ber_meter: 16-QAM BER meter. It searches for the reference-to-received delay, then counts bit errors per 2^WIN_LOG2-symbol window.
// Each result registers one clk after the window's last symbol; there is no backpressure. Macro BER_LOCK_LOSS_EN enables drop-out on windows with high error counts.
module ber_meter #(
  parameter int MAX_DELAY   = 31,
  parameter int SEARCH_LEN  = 64,
  parameter int WIN_LOG2    = 16,
  parameter int LOSS_THRESH = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sym_clk_ena,
  input  logic [1:0]            ref_i,
  input  logic [1:0]            ref_q,
  input  logic [1:0]            rx_i,
  input  logic [1:0]            rx_q,
  input  logic                  clr,
  output logic                  locked,
  output logic [5:0]            delay_out,
  output logic [WIN_LOG2+2:0]   err_count,
  output logic                  meas_valid
);

  localparam int AW = WIN_LOG2 + 3;
  localparam int DW = $clog2(SEARCH_LEN + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SEARCH_LEN - 1);
  localparam logic [5:0]    DELAY_MAX  = 6'(MAX_DELAY);
  localparam logic [AW-1:0] LOSS_T     = AW'(LOSS_THRESH);
`ifdef BER_LOCK_LOSS_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  typedef enum logic {SEARCH, MEASURE} state_t;

  state_t               state;
  logic [3:0]           dline [1:MAX_DELAY];
  logic [3:0]           taps  [0:63];
  logic [DW-1:0]        dwell_cnt;
  logic                 dwell_bad;
  logic [WIN_LOG2-1:0]  win_cnt;
  logic [AW-1:0]        acc;
  logic [AW-1:0]        acc_nxt;
  logic [3:0]           diff;
  logic [2:0]           bit_err;
  logic                 sym_mis;

  // Taps beyond MAX_DELAY read as zero so a full 6-bit select is always legal.
  always_comb begin
    for (int k = 0; k < 64; k++) taps[k] = 4'd0;
    taps[0] = {ref_i, ref_q};
    for (int k = 1; k <= MAX_DELAY; k++) taps[k] = dline[k];
  end

  always_comb begin
    diff    = {rx_i, rx_q} ^ taps[delay_out];
    bit_err = {2'b00, diff[0]} + {2'b00, diff[1]} + {2'b00, diff[2]} + {2'b00, diff[3]};
    sym_mis = |diff;
    acc_nxt = acc + AW'(bit_err);
  end

  // The delay line ignores clr so the history stays valid across a restart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= MAX_DELAY; k++) dline[k] <= 4'd0;
    end else if (sym_clk_ena) begin
      dline[1] <= {ref_i, ref_q};
      for (int k = 2; k <= MAX_DELAY; k++) dline[k] <= dline[k-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SEARCH;
      locked     <= 1'b0;
      delay_out  <= 6'd0;
      err_count  <= '0;
      meas_valid <= 1'b0;
      dwell_cnt  <= '0;
      dwell_bad  <= 1'b0;
      win_cnt    <= '0;
      acc        <= '0;
    end else begin
      meas_valid <= 1'b0;
      if (clr) begin
        state     <= SEARCH;
        locked    <= 1'b0;
        delay_out <= 6'd0;
        dwell_cnt <= '0;
        dwell_bad <= 1'b0;
        win_cnt   <= '0;
        acc       <= '0;
      end else if (sym_clk_ena) begin
        case (state)
          SEARCH: begin
            if (dwell_cnt == DWELL_LAST) begin
              dwell_cnt <= '0;
              dwell_bad <= 1'b0;
              if (!(dwell_bad || sym_mis)) begin
                state   <= MEASURE;
                locked  <= 1'b1;
                win_cnt <= '0;
                acc     <= '0;
              end else begin
                delay_out <= (delay_out == DELAY_MAX) ? 6'd0 : delay_out + 6'd1;
              end
            end else begin
              dwell_cnt <= dwell_cnt + 1'b1;
              dwell_bad <= dwell_bad | sym_mis;
            end
          end
          MEASURE: begin
            if (&win_cnt) begin
              err_count  <= acc_nxt;
              meas_valid <= 1'b1;
              acc        <= '0;
              win_cnt    <= '0;
              if (LOSS_EN && (acc_nxt > LOSS_T)) begin
                state     <= SEARCH;
                locked    <= 1'b0;
                delay_out <= 6'd0;
                dwell_cnt <= '0;
                dwell_bad <= 1'b0;
              end
            end else begin
              acc     <= acc_nxt;
              win_cnt <= win_cnt + 1'b1;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ber_meter.sv
// Directed bench for ber_meter: delay search, window error counts, clr priority and asynchronous reset.
module tb_ber_meter;

  logic       clk;
  logic       reset;
  logic       sym_clk_ena;
  logic       clr;
  logic [1:0] ref_i, ref_q, rx_i, rx_q;
  logic       locked;
  logic       meas_valid;
  logic [5:0] delay_out;
  logic [6:0] err_count;

  int checks;
  int errors;
  int rx_delay;
  logic [3:0] tb_hist [0:63];

  ber_meter #(
    .MAX_DELAY  (31),
    .SEARCH_LEN (64),
    .WIN_LOG2   (4),
    .LOSS_THRESH(10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sym_clk_ena(sym_clk_ena),
    .ref_i      (ref_i),
    .ref_q      (ref_q),
    .rx_i       (rx_i),
    .rx_q       (rx_q),
    .clr        (clr),
    .locked     (locked),
    .delay_out  (delay_out),
    .err_count  (err_count),
    .meas_valid (meas_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gap idle clks, then one symbol clk; outputs of that symbol are visible on return.
  task automatic sym(input logic [3:0] mask, input int gap, input logic do_clr);
    logic [3:0] r;
    repeat (gap) tick();
    r = 4'($urandom_range(0, 15));
    for (int k = 63; k > 0; k--) tb_hist[k] = tb_hist[k-1];
    tb_hist[0] = r;
    {ref_i, ref_q} = r;
    {rx_i, rx_q}   = tb_hist[rx_delay] ^ mask;
    sym_clk_ena = 1'b1;
    clr = do_clr;
    tick();
    sym_clk_ena = 1'b0;
    clr = 1'b0;
  endtask

  task automatic acquire(output int n);
    n = 0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    while (!locked && n < 600) begin
      sym(4'd0, 3, 1'b0);
      n++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int k = 0; k < 64; k++) tb_hist[k] = 4'd0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0d exp 0", locked); end
    checks++; if (delay_out !== 6'd0) begin errors++; $display("FAIL reset_delay got %0d exp 0", delay_out); end
    checks++; if (err_count !== 7'd0) begin errors++; $display("FAIL reset_err got %0d exp 0", err_count); end
    checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL reset_mv got %0d exp 0", meas_valid); end
  endtask

  task automatic test_search_lock();
    int n;
    rx_delay = 5;
    acquire(n);
    checks++; if (!(n >= 384 && n <= 448)) begin errors++; $display("FAIL lock5_symbols got %0d exp 384..448", n); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock5_locked got %0d exp 1", locked); end
    checks++; if (delay_out !== 6'd5) begin errors++; $display("FAIL lock5_delay got %0d exp 5", delay_out); end
  endtask

  task automatic test_one_bit_errors();
    int n;
    rx_delay = 5;
    acquire(n);
    for (int i = 1; i <= 16; i++) begin
      sym(4'b0001, 3, 1'b0);
      if (i == 15) begin
        checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL win1_early_mv got %0d exp 0", meas_valid); end
      end
    end
    checks++; if (meas_valid !== 1'b1) begin errors++; $display("FAIL win1_mv got %0d exp 1", meas_valid); end
    checks++; if (err_count !== 7'd16) begin errors++; $display("FAIL win1_err got %0d exp 16", err_count); end
    tick();
    checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL win1_mv_pulse got %0d exp 0", meas_valid); end
`ifdef BER_LOCK_LOSS_EN
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL win1_loss_locked got %0d exp 0", locked); end
`else
    for (int i = 1; i <= 16; i++) sym(4'b1000, 3, 1'b0);
    checks++; if (meas_valid !== 1'b1) begin errors++; $display("FAIL win2_mv got %0d exp 1", meas_valid); end
    checks++; if (err_count !== 7'd16) begin errors++; $display("FAIL win2_err got %0d exp 16", err_count); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL win2_locked got %0d exp 1", locked); end
`endif
  endtask

  task automatic test_full_window();
    int n;
    rx_delay = 5;
    acquire(n);
    for (int i = 1; i <= 16; i++) sym(4'b1111, 3, 1'b0);
    checks++; if (meas_valid !== 1'b1) begin errors++; $display("FAIL full_mv got %0d exp 1", meas_valid); end
    checks++; if (err_count !== 7'd64) begin errors++; $display("FAIL full_err got %0d exp 64", err_count); end
  endtask

  task automatic test_loss_thresh();
    int n;
    rx_delay = 5;
    acquire(n);
    for (int i = 1; i <= 16; i++) sym((i <= 10) ? 4'b0100 : 4'b0000, 3, 1'b0);
    checks++; if (err_count !== 7'd10) begin errors++; $display("FAIL thr10_err got %0d exp 10", err_count); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL thr10_locked got %0d exp 1", locked); end
    for (int i = 1; i <= 16; i++) sym((i <= 11) ? 4'b0010 : 4'b0000, 0, 1'b0);
    checks++; if (meas_valid !== 1'b1) begin errors++; $display("FAIL thr11_mv got %0d exp 1", meas_valid); end
    checks++; if (err_count !== 7'd11) begin errors++; $display("FAIL thr11_err got %0d exp 11", err_count); end
`ifdef BER_LOCK_LOSS_EN
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL thr11_locked got %0d exp 0", locked); end
    checks++; if (delay_out !== 6'd0) begin errors++; $display("FAIL thr11_delay got %0d exp 0", delay_out); end
`else
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL thr11_locked got %0d exp 1", locked); end
    checks++; if (delay_out !== 6'd5) begin errors++; $display("FAIL thr11_delay got %0d exp 5", delay_out); end
`endif
  endtask

  task automatic test_clr_priority();
    int n;
    rx_delay = 5;
    acquire(n);
    for (int i = 1; i <= 16; i++) sym((i <= 3) ? 4'b0001 : 4'b0000, 3, 1'b0);
    checks++; if (err_count !== 7'd3) begin errors++; $display("FAIL clrp_pre_err got %0d exp 3", err_count); end
    for (int i = 1; i <= 15; i++) sym(4'b0010, 3, 1'b0);
    sym(4'b0010, 3, 1'b1);
    checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL clrp_mv got %0d exp 0", meas_valid); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL clrp_locked got %0d exp 0", locked); end
    checks++; if (delay_out !== 6'd0) begin errors++; $display("FAIL clrp_delay got %0d exp 0", delay_out); end
    checks++; if (err_count !== 7'd3) begin errors++; $display("FAIL clrp_err got %0d exp 3", err_count); end
    for (int i = 1; i <= 10; i++) sym(4'd0, 3, 1'b0);
    checks++; if (err_count !== 7'd3) begin errors++; $display("FAIL clrp_hold_err got %0d exp 3", err_count); end
  endtask

  task automatic test_back_to_back_wrap();
    int n;
    rx_delay = 40;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (n = 0; n < 31 * 64; n++) sym(4'd0, 0, 1'b0);
    checks++; if (delay_out !== 6'd31) begin errors++; $display("FAIL wrap_d31 got %0d exp 31", delay_out); end
    for (int i = 0; i < 64; i++) sym(4'd0, 0, 1'b0);
    checks++; if (delay_out !== 6'd0) begin errors++; $display("FAIL wrap_d0 got %0d exp 0", delay_out); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL wrap_locked got %0d exp 0", locked); end
  endtask

  task automatic test_delay0_and_async_reset();
    do_reset();
    rx_delay = 0;
    for (int i = 1; i <= 63; i++) sym(4'd0, 3, 1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL d0_early_locked got %0d exp 0", locked); end
    sym(4'd0, 3, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL d0_locked got %0d exp 1", locked); end
    checks++; if (delay_out !== 6'd0) begin errors++; $display("FAIL d0_delay got %0d exp 0", delay_out); end
    for (int i = 1; i <= 16; i++) sym((i == 4 || i == 9) ? 4'b1000 : 4'b0000, 3, 1'b0);
    checks++; if (err_count !== 7'd2) begin errors++; $display("FAIL d0_err got %0d exp 2", err_count); end
    for (int i = 1; i <= 5; i++) sym(4'b0001, 3, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL arst_locked got %0d exp 0", locked); end
    checks++; if (delay_out !== 6'd0) begin errors++; $display("FAIL arst_delay got %0d exp 0", delay_out); end
    checks++; if (err_count !== 7'd0) begin errors++; $display("FAIL arst_err got %0d exp 0", err_count); end
    checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL arst_mv got %0d exp 0", meas_valid); end
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      sym(4'd0, 3, 1'b0);
      if (meas_valid !== 1'b0) begin
        checks++; errors++;
        $display("FAIL arst_partial_mv got %0d exp 0", meas_valid);
      end
    end
    checks++; if (err_count !== 7'd0) begin errors++; $display("FAIL arst_after_err got %0d exp 0", err_count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rx_delay = 0;
    reset = 1'b1;
    sym_clk_ena = 1'b0;
    clr = 1'b0;
    ref_i = 2'd0; ref_q = 2'd0; rx_i = 2'd0; rx_q = 2'd0;
    test_reset();
    test_search_lock();
    test_one_bit_errors();
    test_full_window();
    test_loss_thresh();
    test_clr_priority();
    test_back_to_back_wrap();
    test_delay0_and_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
